inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Program loader directly upstream of the instruction memory.
- Accepts a stream of 9-bit instruction words over a valid/ready handshake and writes them sequentially into the 64-entry instruction store.
- Holds the processor core in reset while loading, then releases it so the program counter starts fetching at address 0.
- Sits between the testbench/host load port and the instruction memory write port; drives the core's reset.

Parameters:
- INST_W, 9, instruction word width.
- ADDR_W, 6, instruction address width (matches the 6-bit PC).
- DEPTH, 64, number of instruction slots; must equal 2**ADDR_W.
- RELEASE_CYCLES, 2, cycles core_reset stays high after the last write before release; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a (re)load.
- in_valid  in  1  host word valid.
- in_data  in  INST_W  host instruction word.
- in_last  in  1  marks the final word of the program; qualified by in_valid.
- in_ready  out  1  loader can accept a word this cycle.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  ADDR_W  instruction memory write address.
- wr_data  out  INST_W  instruction memory write data.
- core_reset  out  1  reset to the core (PC, regfile); active-high.
- load_done  out  1  program loaded and core running.
- overflow_err  out  1  more than DEPTH words were offered.
- word_count  out  ADDR_W+1  number of words written in the current load (0..64).

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, core_reset=1, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, load_done=0, overflow_err=0, word_count=0, release counter=0.
- All outputs are registered except in_ready, which is a decode of state (1 only in LOAD).
- A transfer occurs when in_valid && in_ready at a rising edge.
- IDLE: core_reset=1. start -> LOAD, word_count cleared.
- LOAD:
  - Each transfer with word_count<DEPTH: next cycle wr_en=1, wr_addr=word_count[ADDR_W-1:0], wr_data=in_data, and word_count increments. Write latency is exactly 1 cycle after the handshake.
  - wr_en is 0 in every cycle not following a transfer.
  - Transfer with in_last=1: the word is written, then go to RELEASE with the counter loaded to RELEASE_CYCLES.
  - Transfer when word_count==DEPTH: word not written (wr_en stays 0), overflow_err=1, go to ERROR. This applies whether or not in_last is set.
  - The 64th word with in_last=1 is legal: it is written and the block goes to RELEASE.
  - start during LOAD is ignored.
  - in_last with in_valid=0 is ignored.
- RELEASE: core_reset=1, in_ready=0. Counter decrements each cycle. When the counter reaches 0 (on that edge) go to RUN: core_reset=0 and load_done=1 from the next cycle.
  - Net effect: core_reset falls RELEASE_CYCLES+1 cycles after the last write strobe.
- RUN: core_reset=0, load_done=1.
  - start -> LOAD. The next cycle has core_reset=1, load_done=0, word_count=0.
  - Instruction memory contents beyond the new program are not cleared.
- ERROR: core_reset=1, load_done=0, overflow_err held.
  - start -> LOAD and clears overflow_err.
  - Host words offered in ERROR are not accepted (in_ready=0).
- Asynchronous reset mid-load: immediate return to reset values. Partially written memory is left as is; a fresh start is required.
- Simultaneous start and a transfer in IDLE: the word is not accepted, because in_ready=0 in IDLE.

Decomposition:
- Shared package (isa_pkg): INST_W, ADDR_W, DEPTH constants and the loader_state_t enum {IDLE, LOAD, RELEASE, RUN, ERROR}.
- No sub-module is needed. The release down-counter and the word counter are inline.
- The top level wires wr_* to the instruction memory write port and core_reset into the program counter and register file resets, OR-ed with the system reset.

Test Plan:
- Reset then idle: reset high for 3 cycles, then low with no start -> core_reset=1, in_ready=0, wr_en never 1, word_count=0.
- Basic load: start, then words 0x1A5, 0x0C3, 0x1FF (last) on consecutive cycles -> wr_en on 3 consecutive cycles, each 1 cycle after its handshake, with addr 0,1,2 carrying those data. word_count=3. With RELEASE_CYCLES=2, core_reset falls 3 cycles after the last wr_en and load_done=1.
- Backpressure/gaps: in_valid toggled 1,0,0,1(last) with data 0x011, 0x022 -> exactly 2 writes at addr 0,1. No write in the gap cycles.
- Full program: 64 words, the last with in_last -> final write at addr 63, word_count=64, then RELEASE and RUN with overflow_err=0.
- Overflow: 65 words, no in_last through word 64 -> 64 writes, and the 65th is not written. overflow_err=1, state ERROR, core_reset=1. A subsequent start clears overflow_err and in_ready=1.
- Reload and async reset: in RUN, pulse start -> core_reset=1 next cycle and word_count=0. Load 2 words, then assert reset between them -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared instruction-store constants and the program loader state encoding.
package isa_pkg;

    localparam int INST_W = 9;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        ERROR   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/inst_loader.sv
// Program loader: streams host words into the instruction store and holds the
// core in reset until the program is complete.
module inst_loader #(
    parameter int INST_W         = isa_pkg::INST_W,
    parameter int ADDR_W         = isa_pkg::ADDR_W,
    parameter int DEPTH          = isa_pkg::DEPTH,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [INST_W-1:0] wr_data,
    output logic              core_reset,
    output logic              load_done,
    output logic              overflow_err,
    output logic [ADDR_W:0]   word_count
);

    import isa_pkg::*;

    if (DEPTH != (1 << ADDR_W)) begin : g_depth_chk
        $error("inst_loader: DEPTH must equal 2**ADDR_W");
    end
    if (RELEASE_CYCLES < 1 || RELEASE_CYCLES > 15) begin : g_rel_chk
        $error("inst_loader: RELEASE_CYCLES must be in 1..15");
    end

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      REL_LOAD   = 4'(RELEASE_CYCLES);

    loader_state_t state, next_state;
    logic [3:0]    rel_cnt;
    logic          xfer;
    logic          full;
    logic          wr_fire;
    logic          begin_load;
    logic          running;

    assign in_ready   = (state == LOAD);
    assign xfer       = in_valid && in_ready;
    assign full       = (word_count == FULL_COUNT);
    assign wr_fire    = xfer && !full;
    assign begin_load = (state != LOAD) && (next_state == LOAD);
    // The core only leaves reset once RUN has been held for a full cycle,
    // so a restart from RUN re-asserts core_reset on the very next edge.
    assign running    = (state == RUN) && (next_state == RUN);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) next_state = LOAD;
            end
            LOAD: begin
                if (xfer) begin
                    if (full)         next_state = ERROR;
                    else if (in_last) next_state = RELEASE;
                end
            end
            RELEASE: begin
                if (rel_cnt <= 4'd1) next_state = RUN;
            end
            RUN: begin
                if (start) next_state = LOAD;
            end
            ERROR: begin
                if (start) next_state = LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en        <= 1'b0;
            core_reset   <= 1'b1;
            load_done    <= 1'b0;
            overflow_err <= 1'b0;
            word_count   <= '0;
            rel_cnt      <= '0;
        end else begin
            wr_en      <= wr_fire;
            core_reset <= !running;
            load_done  <= running;

            if (begin_load) begin
                word_count   <= '0;
                overflow_err <= 1'b0;
            end else if (wr_fire) begin
                word_count <= word_count + 1'b1;
            end

            if (xfer && full) begin
                overflow_err <= 1'b1;
            end

            if (wr_fire && in_last) begin
                rel_cnt <= REL_LOAD;
            end else if (state == RELEASE && rel_cnt != 4'd0) begin
                rel_cnt <= rel_cnt - 1'b1;
            end
        end
    end

    // Write port: address and data hold their last value between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr <= '0;
            wr_data <= '0;
        end else if (wr_fire) begin
            wr_addr <= word_count[ADDR_W-1:0];
            wr_data <= in_data;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a write-port scoreboard.
module tb_inst_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [8:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [8:0] wr_data;
    logic       core_reset;
    logic       load_done;
    logic       overflow_err;
    logic [6:0] word_count;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [14:0] exp_q[$];
    logic [14:0] mon_e;

    inst_loader #(.RELEASE_CYCLES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .core_reset  (core_reset),
        .load_done   (load_done),
        .overflow_err(overflow_err),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; wr says whether a write to addr must follow one cycle later.
    task automatic send(input logic [8:0] d, input logic last, input bit wr, input int addr);
        logic [5:0] a;
        a = addr[5:0];
        chk("in_ready_before_xfer", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        if (wr) exp_q.push_back({a, d});
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("wr_en_latency", int'(wr_en), int'(wr));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!reset && wr_en) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected",
                                 wr_addr, wr_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("wr_addr", int'(wr_addr), int'(mon_e[14:9]));
                        chk("wr_data", int'(wr_data), int'(mon_e[8:0]));
                    end
                end
            end
        join_none

        // Reset held for three cycles, then idle without start.
        repeat (3) tick();
        chk("rst_core_reset", int'(core_reset), 1);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        reset = 1'b0;
        repeat (4) tick();
        chk("idle_core_reset", int'(core_reset), 1);
        chk("idle_in_ready", int'(in_ready), 0);
        chk("idle_word_count", int'(word_count), 0);
        chk("idle_load_done", int'(load_done), 0);

        // Basic three-word load and release timing.
        pulse_start();
        chk("load_in_ready", int'(in_ready), 1);
        send(9'h1A5, 1'b0, 1'b1, 0);
        send(9'h0C3, 1'b0, 1'b1, 1);
        send(9'h1FF, 1'b1, 1'b1, 2);
        chk("basic_word_count", int'(word_count), 3);
        chk("basic_core_reset_c1", int'(core_reset), 1);
        tick();
        chk("basic_core_reset_c2", int'(core_reset), 1);
        chk("basic_in_ready_release", int'(in_ready), 0);
        tick();
        chk("basic_core_reset_c3", int'(core_reset), 1);
        chk("basic_load_done_c3", int'(load_done), 0);
        tick();
        chk("basic_core_reset_c4", int'(core_reset), 0);
        chk("basic_load_done_c4", int'(load_done), 1);

        // Reload from RUN, with gaps and a stray in_last while invalid.
        pulse_start();
        chk("reload_core_reset", int'(core_reset), 1);
        chk("reload_load_done", int'(load_done), 0);
        chk("reload_word_count", int'(word_count), 0);
        send(9'h011, 1'b0, 1'b1, 0);
        in_last = 1'b1;
        tick();
        chk("gap1_wr_en", int'(wr_en), 0);
        tick();
        chk("gap2_wr_en", int'(wr_en), 0);
        in_last = 1'b0;
        send(9'h022, 1'b1, 1'b1, 1);
        chk("gap_word_count", int'(word_count), 2);
        repeat (3) tick();
        chk("gap_load_done", int'(load_done), 1);

        // Full 64-word program.
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            send(9'((i * 37 + 5) & 9'h1FF), (i == 63), 1'b1, i);
        end
        chk("full_word_count", int'(word_count), 64);
        repeat (3) tick();
        chk("full_load_done", int'(load_done), 1);
        chk("full_core_reset", int'(core_reset), 0);
        chk("full_overflow", int'(overflow_err), 0);

        // Overflow: 65 words without in_last.
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            send(9'((i * 11 + 3) & 9'h1FF), 1'b0, 1'b1, i);
        end
        send(9'h155, 1'b0, 1'b0, 0);
        chk("ovf_flag", int'(overflow_err), 1);
        chk("ovf_in_ready", int'(in_ready), 0);
        chk("ovf_core_reset", int'(core_reset), 1);
        chk("ovf_load_done", int'(load_done), 0);
        chk("ovf_word_count", int'(word_count), 64);
        in_valid = 1'b1;
        in_data  = 9'h0AA;
        tick();
        in_valid = 1'b0;
        chk("err_no_write", int'(wr_en), 0);
        chk("err_flag_held", int'(overflow_err), 1);
        pulse_start();
        chk("err_restart_flag", int'(overflow_err), 0);
        chk("err_restart_ready", int'(in_ready), 1);
        chk("err_restart_count", int'(word_count), 0);

        // Asynchronous reset between two words of a load.
        send(9'h123, 1'b0, 1'b1, 0);
        chk("pre_rst_word_count", int'(word_count), 1);
        #5;
        reset = 1'b1;
        #1;
        chk("async_wr_en", int'(wr_en), 0);
        chk("async_word_count", int'(word_count), 0);
        chk("async_in_ready", int'(in_ready), 0);
        chk("async_core_reset", int'(core_reset), 1);
        chk("async_wr_addr", int'(wr_addr), 0);
        chk("async_wr_data", int'(wr_data), 0);
        chk("async_load_done", int'(load_done), 0);
        chk("async_overflow", int'(overflow_err), 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("pending_writes", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
